trigger_frame_decoder: RTL
==========================

TRIGGER_FRAME_DECODER -- requirements
Module: trigger_frame_decoder

Interface
REQ-001 SHALL have parameter FRAME_DATA_WORDS, default 25, meaning 64-bit data words per frame after the header (100 samples).
REQ-002 SHALL have parameter TIME_STAMP_WIDTH, default 16, meaning header time-stamp width.
REQ-003 SHALL have parameter ADC_RESOLUTION_WIDTH, default 12, meaning sample bits per 16-bit lane.
REQ-004 SHALL have parameter HDR_MARKER, default 8'hA5, meaning required header[63:56].
REQ-005 SHALL have these ports: AXIS_ACLK in 1, the one clock; AXIS_ARESET in 1, reset, asynchronous active-high.
REQ-006 SHALL have these slave ports: S_AXIS_TDATA in 64, frame word; S_AXIS_TVALID in 1; S_AXIS_TREADY out 1; S_AXIS_TLAST in 1; S_AXIS_TUSER in 1, header-word flag.
REQ-007 SHALL have these master ports: M_AXIS_TDATA out 48, four unpacked samples; M_AXIS_TVALID out 1; M_AXIS_TREADY in 1; M_AXIS_TLAST out 1.
REQ-008 SHALL have these status ports: O_TIME_STAMP out 16, last header time stamp; O_BASELINE out 12, last header baseline; O_HDR_VALID out 1, one-cycle header pulse.
REQ-009 SHALL have these error ports: O_ERR_HDR, O_ERR_SHORT, O_ERR_LONG out 1 each, one-cycle pulses; O_ERR_COUNT out 16, saturating error total.

Function
REQ-010 SHALL define the header as [63:56] marker, [55:40] time stamp, [39:28] baseline, and [27:0] ignored, with TUSER=1.
REQ-011 SHALL unpack a data word so that lane k=S_AXIS_TDATA[16k+11:16k] maps to M_AXIS_TDATA[12k+11:12k], for k=0..3; lane bits [15:12] are dropped.
REQ-012 SHALL implement states IDLE (await header), DATA (forward words), and DROP (discard to TLAST).
REQ-013 In IDLE, SHALL hold S_AXIS_TREADY=1; when an accepted word has TUSER=1 and a matching marker, SHALL latch O_TIME_STAMP and O_BASELINE, pulse O_HDR_VALID next cycle, clear the word counter, and go to DATA.
REQ-014 In IDLE, an accepted word with TUSER=0 or a wrong marker SHALL pulse O_ERR_HDR and go to DROP, or stay in IDLE if that word has TLAST=1.
REQ-015 A header carrying TLAST=1 SHALL pulse O_ERR_SHORT and stay in IDLE.
REQ-016 In DATA, SHALL drive S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY using a single output register with no combinational TVALID-to-TREADY path.
REQ-017 A data word accepted in cycle N SHALL appear on M_AXIS_TDATA with M_AXIS_TVALID=1 in cycle N+1.
REQ-018 Output SHALL hold stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-019 If the word counter reaches FRAME_DATA_WORDS together with TLAST, SHALL set M_AXIS_TLAST=1 on that word and return to IDLE.
REQ-020 If TLAST arrives earlier, SHALL forward that word with M_AXIS_TLAST=1, pulse O_ERR_SHORT, and return to IDLE.
REQ-021 If word FRAME_DATA_WORDS arrives without TLAST, SHALL forward it with M_AXIS_TLAST=1, pulse O_ERR_LONG, and go to DROP.
REQ-022 In DATA, TUSER=1 SHALL be ignored for framing.
REQ-023 In DROP, SHALL hold S_AXIS_TREADY=1, discard words, and return to IDLE on an accepted TLAST word.
REQ-024 Output frames SHALL always terminate with M_AXIS_TLAST; no output word SHALL be produced for headers or dropped words.
REQ-025 O_ERR_COUNT SHALL increment once per error pulse cycle and saturate at 16'hFFFF; simultaneous pulses SHALL count once.

Reset
REQ-026 AXIS_ARESET=1 SHALL asynchronously force IDLE, counter 0, S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, O_TIME_STAMP=0, O_BASELINE=0, all pulses 0, and O_ERR_COUNT=0.
REQ-027 Reset mid-frame SHALL discard the pending output word; S_AXIS_TREADY SHALL rise the first clock after release.

Configuration
REQ-028 With macro TRG_DECODER_ERR_COUNT_EN defined, O_ERR_COUNT SHALL behave per REQ-025; undefined, O_ERR_COUNT SHALL be constant 0, no counter logic SHALL exist, and pulses SHALL be unaffected.

Verification
REQ-029 SHALL cover a nominal frame: header 0xA5_1234_7D0_0000000 with TUSER=1, then 25 words of lanes 0x0001..0x0064 with TLAST on word 25 -> O_TIME_STAMP=0x1234, O_BASELINE=0x7D0, 25 outputs, TLAST on the 25th, no errors.
REQ-030 SHALL cover backpressure: M_AXIS_TREADY toggled 1-0-0-1 -> data held stable, no loss or duplication, S_AXIS_TREADY=0 while the output is full.
REQ-031 SHALL cover a short frame: TLAST on data word 10 -> 10 outputs, M_AXIS_TLAST on the 10th, one O_ERR_SHORT pulse, next header accepted.
REQ-032 SHALL cover a long frame: 30 data words, TLAST on the 30th -> 25 outputs with TLAST on the 25th, one O_ERR_LONG pulse, 5 words dropped.
REQ-033 SHALL cover a bad header: marker 0x5A -> one O_ERR_HDR pulse, no outputs until the frame after the next TLAST; with the macro, O_ERR_COUNT=1.
REQ-034 SHALL cover reset: AXIS_ARESET asserted at data word 12 -> all outputs at reset values immediately, a clean frame decoded afterwards.

Source files
------------

// File: rtl/trigger_frame_decoder.sv
// trigger_frame_decoder: header-framed AXIS decoder unpacking four ADC lanes per 64-bit word.
// Optional saturating error counter is built only when TRG_DECODER_ERR_COUNT_EN is defined.
module trigger_frame_decoder #(
   parameter int FRAME_DATA_WORDS = 25,
   parameter int TIME_STAMP_WIDTH = 16,
   parameter int ADC_RESOLUTION_WIDTH = 12,
   parameter logic [7:0] HDR_MARKER = 8'hA5
) (
   input  logic AXIS_ACLK,
   input  logic AXIS_ARESET,
   input  logic [63:0] S_AXIS_TDATA,
   input  logic S_AXIS_TVALID,
   output logic S_AXIS_TREADY,
   input  logic S_AXIS_TLAST,
   input  logic S_AXIS_TUSER,
   output logic [4*ADC_RESOLUTION_WIDTH-1:0] M_AXIS_TDATA,
   output logic M_AXIS_TVALID,
   input  logic M_AXIS_TREADY,
   output logic M_AXIS_TLAST,
   output logic [TIME_STAMP_WIDTH-1:0] O_TIME_STAMP,
   output logic [ADC_RESOLUTION_WIDTH-1:0] O_BASELINE,
   output logic O_HDR_VALID,
   output logic O_ERR_HDR,
   output logic O_ERR_SHORT,
   output logic O_ERR_LONG,
   output logic [15:0] O_ERR_COUNT
);
   localparam int CW = $clog2(FRAME_DATA_WORDS + 1);
   typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
   state_t state;
   logic [CW-1:0] word_cnt;
   logic rdy_en;
   logic s_acc;
   logic hdr_ok;
   logic last_word;
   logic unused_bits;
   logic [4*ADC_RESOLUTION_WIDTH-1:0] unpacked;
   // rdy_en keeps TREADY low during reset and for the first edge after release
   assign S_AXIS_TREADY = rdy_en && (state != DATA || !M_AXIS_TVALID || M_AXIS_TREADY);
   assign s_acc = S_AXIS_TVALID && S_AXIS_TREADY;
   assign hdr_ok = S_AXIS_TUSER && S_AXIS_TDATA[63:56] == HDR_MARKER;
   assign last_word = word_cnt == CW'(FRAME_DATA_WORDS - 1);
   assign unused_bits = ^S_AXIS_TDATA;
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign unpacked[k*ADC_RESOLUTION_WIDTH +: ADC_RESOLUTION_WIDTH] = S_AXIS_TDATA[16*k +: ADC_RESOLUTION_WIDTH];
   end
   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) begin
         state <= IDLE;
         word_cnt <= '0;
         rdy_en <= 1'b0;
         M_AXIS_TDATA <= '0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TLAST <= 1'b0;
         O_TIME_STAMP <= '0;
         O_BASELINE <= '0;
         O_HDR_VALID <= 1'b0;
         O_ERR_HDR <= 1'b0;
         O_ERR_SHORT <= 1'b0;
         O_ERR_LONG <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         O_HDR_VALID <= 1'b0;
         O_ERR_HDR <= 1'b0;
         O_ERR_SHORT <= 1'b0;
         O_ERR_LONG <= 1'b0;
         if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
         if (s_acc) begin
            case (state)
               IDLE: begin
                  if (hdr_ok) begin
                     O_TIME_STAMP <= S_AXIS_TDATA[40 +: TIME_STAMP_WIDTH];
                     O_BASELINE <= S_AXIS_TDATA[28 +: ADC_RESOLUTION_WIDTH];
                     O_HDR_VALID <= 1'b1;
                     word_cnt <= '0;
                     O_ERR_SHORT <= S_AXIS_TLAST;
                     state <= S_AXIS_TLAST ? IDLE : DATA;
                  end else begin
                     O_ERR_HDR <= 1'b1;
                     state <= S_AXIS_TLAST ? IDLE : DROP;
                  end
               end
               DATA: begin
                  M_AXIS_TDATA <= unpacked;
                  M_AXIS_TVALID <= 1'b1;
                  M_AXIS_TLAST <= S_AXIS_TLAST || last_word;
                  word_cnt <= word_cnt + 1'b1;
                  O_ERR_SHORT <= S_AXIS_TLAST && !last_word;
                  O_ERR_LONG <= !S_AXIS_TLAST && last_word;
                  state <= S_AXIS_TLAST ? IDLE : last_word ? DROP : DATA;
               end
               DROP: state <= S_AXIS_TLAST ? IDLE : DROP;
               default: state <= IDLE;
            endcase
         end
      end
   end
`ifdef TRG_DECODER_ERR_COUNT_EN
   logic [15:0] err_count;
   always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
      if (AXIS_ARESET) err_count <= '0;
      else if ((O_ERR_HDR || O_ERR_SHORT || O_ERR_LONG) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
   end
   assign O_ERR_COUNT = err_count;
`else
   assign O_ERR_COUNT = '0;
`endif
endmodule
